// File: rtl/l2_way_data_array.sv
// Multi-way L2 data store: all ways of every set, per-byte write mask, registered read port.
// Read latency 1 cycle (dataout/dataout_valid registered); writes land at the capturing edge.
// No backpressure: read_en/write_en are ignored while init_busy is high, otherwise accepted every cycle.
//
// Ports:
//   clk, rst_n         rising-edge clock, synchronous active-low reset
//   init_busy          high from reset until the post-reset clear of every set completes
//   read_en/rindex/rway                  read request (set, way)
//   write_en/windex/wway/wmask/datain    masked write request (wmask bit i -> datain byte i)
//   dataout/dataout_valid                registered read result of the previous cycle's read
// Optional macro L2_WAY_DARRAY_WR_BYPASS_EN: a same-cycle read and write of the same set/way
// returns the merged line instead of the pre-write line.
module l2_way_data_array #(
   parameter int s_offset = 5,
   parameter int s_index  = 3,
   parameter int num_ways = 4,
   localparam int s_mask   = 2**s_offset,
   localparam int s_line   = 8*s_mask,
   localparam int num_sets = 2**s_index,
   localparam int s_way    = ($clog2(num_ways) > 1) ? $clog2(num_ways) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               init_busy,
   input  logic               read_en,
   input  logic [s_index-1:0] rindex,
   input  logic [s_way-1:0]   rway,
   input  logic               write_en,
   input  logic [s_index-1:0] windex,
   input  logic [s_way-1:0]   wway,
   input  logic [s_mask-1:0]  wmask,
   input  logic [s_line-1:0]  datain,
   output logic [s_line-1:0]  dataout,
   output logic               dataout_valid
);

   typedef enum logic {CLEAR, READY} state_t;

   localparam logic [s_index-1:0] last_set = s_index'(num_sets - 1);

   state_t             state, state_nxt;
   logic [s_index-1:0] clear_cnt, clear_cnt_nxt;

   // Flop-based storage; no reset so reset itself never touches contents.
   logic [s_line-1:0] data [num_sets][num_ways];

   logic              rway_ok, wway_ok;
   logic              rd_fire, wr_fire;
   logic [s_way-1:0]  rway_safe;
   logic [s_line-1:0] wbits;
   logic [s_line-1:0] rd_raw, rd_line;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= CLEAR;
         clear_cnt <= '0;
      end else begin
         state     <= state_nxt;
         clear_cnt <= clear_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      clear_cnt_nxt = clear_cnt;
      case (state)
         CLEAR: begin
            clear_cnt_nxt = clear_cnt + s_index'(1);
            if (clear_cnt == last_set) state_nxt = READY;
         end
         READY: state_nxt = READY;
         default: state_nxt = CLEAR;
      endcase
   end

   assign init_busy = (state == CLEAR);

   // ---------------- request qualification ----------------
   // Ways beyond num_ways only exist when num_ways is not a power of two.
   assign rway_ok   = int'(rway) < num_ways;
   assign wway_ok   = int'(wway) < num_ways;
   assign rd_fire   = (state == READY) && read_en;
   assign wr_fire   = (state == READY) && write_en && wway_ok;
   assign rway_safe = rway_ok ? rway : '0;

   always_comb begin
      wbits = '0;
      for (int i = 0; i < s_mask; i++) wbits[8*i +: 8] = {8{wmask[i]}};
   end

   assign rd_raw = data[rindex][rway_safe];

   always_comb begin
      rd_line = '0;
      if (rway_ok) begin
         rd_line = rd_raw;
`ifdef L2_WAY_DARRAY_WR_BYPASS_EN
         // wr_fire already excludes out-of-range ways, so those never bypass.
         if (wr_fire && (windex == rindex) && (wway == rway))
            rd_line = (rd_raw & ~wbits) | (datain & wbits);
`endif
      end
   end

   // ---------------- storage ----------------
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == CLEAR) begin
            for (int w = 0; w < num_ways; w++) data[clear_cnt][w] <= '0;
         end else if (wr_fire) begin
            data[windex][wway] <= (data[windex][wway] & ~wbits) | (datain & wbits);
         end
      end
   end

   // ---------------- read port ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dataout       <= '0;
         dataout_valid <= 1'b0;
      end else if (rd_fire) begin
         dataout       <= rd_line;
         dataout_valid <= 1'b1;
      end else begin
         dataout_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_l2_way_data_array.sv
module tb_l2_way_data_array;

   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          init_busy;
   logic          read_en, write_en;
   logic [2:0]    rindex, windex;
   logic [1:0]    rway, wway;
   logic [31:0]   wmask;
   logic [LW-1:0] datain, dataout;
   logic          dataout_valid;

   // Second instance built with a non power-of-two way count.
   logic          init_busy3;
   logic          read_en3, write_en3;
   logic [2:0]    rindex3, windex3;
   logic [1:0]    rway3, wway3;
   logic [31:0]   wmask3;
   logic [LW-1:0] datain3, dataout3;
   logic          dataout_valid3;

   l2_way_data_array dut (
      .clk(clk), .rst_n(rst_n), .init_busy(init_busy),
      .read_en(read_en), .rindex(rindex), .rway(rway),
      .write_en(write_en), .windex(windex), .wway(wway), .wmask(wmask), .datain(datain),
      .dataout(dataout), .dataout_valid(dataout_valid)
   );

   l2_way_data_array #(.num_ways(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .init_busy(init_busy3),
      .read_en(read_en3), .rindex(rindex3), .rway(rway3),
      .write_en(write_en3), .windex(windex3), .wway(wway3), .wmask(wmask3), .datain(datain3),
      .dataout(dataout3), .dataout_valid(dataout_valid3)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   logic [LW-1:0] mem [8][4];
   logic          mready;
   int            mcnt;
   logic [LW-1:0] last_dout;
   logic [LW-1:0] exp_q [$];

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [LW-1:0] merge(input logic [LW-1:0] old, input logic [LW-1:0] nw,
                                           input logic [31:0] m);
      logic [LW-1:0] r;
      r = old;
      for (int i = 0; i < 32; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   // Advance the main DUT one cycle: update the model with the driven inputs,
   // push any expected read result, then check outputs just after the edge.
   task automatic step();
      logic [LW-1:0] e;
      logic          ve;
      ve = 1'b0;
      if (!rst_n) begin
         mready    = 1'b0;
         mcnt      = 0;
         last_dout = '0;
      end else if (!mready) begin
         for (int w = 0; w < 4; w++) mem[mcnt][w] = '0;
         if (mcnt == 7) mready = 1'b1;
         else mcnt++;
      end else begin
         if (read_en) begin
            e = mem[rindex][rway];
`ifdef L2_WAY_DARRAY_WR_BYPASS_EN
            if (write_en && windex == rindex && wway == rway) e = merge(e, datain, wmask);
`endif
            exp_q.push_back(e);
            ve = 1'b1;
         end
         if (write_en) mem[windex][wway] = merge(mem[windex][wway], datain, wmask);
      end
      @(posedge clk);
      #1;
      read_en  = 1'b0;
      write_en = 1'b0;
      check("init_busy", LW'(init_busy), LW'(!mready));
      check("dataout_valid", LW'(dataout_valid), LW'(ve));
      if (ve) begin
         check("sb_depth", LW'(exp_q.size()), LW'(1));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rdata", dataout, e);
            last_dout = e;
         end
      end else begin
         check("dout_hold", dataout, last_dout);
      end
   endtask

   task automatic set_wr(input int idx, input int way, input logic [31:0] m, input logic [LW-1:0] d);
      write_en = 1'b1; windex = 3'(idx); wway = 2'(way); wmask = m; datain = d;
   endtask

   task automatic set_rd(input int idx, input int way);
      read_en = 1'b1; rindex = 3'(idx); rway = 2'(way);
   endtask

   task automatic tick3();
      @(posedge clk);
      #1;
      read_en3  = 1'b0;
      write_en3 = 1'b0;
   endtask

   task automatic count_init(input string tag);
      int n;
      n = 0;
      while (init_busy && n < 20) begin
         step();
         n++;
      end
      check(tag, LW'(n), LW'(8));
   endtask

   initial begin
      logic [LW-1:0] pat;
      rst_n = 1'b0;
      read_en = 0; write_en = 0; rindex = 0; windex = 0; rway = 0; wway = 0; wmask = 0; datain = '0;
      read_en3 = 0; write_en3 = 0; rindex3 = 0; windex3 = 0; rway3 = 0; wway3 = 0; wmask3 = 0; datain3 = '0;
      mready = 0; mcnt = 0; last_dout = '0;

      // Init sequence with a read issued during the clear (ignored).
      repeat (3) step();
      rst_n = 1'b1;
      begin
         int n;
         n = 0;
         while (init_busy && n < 20) begin
            if (n == 3) set_rd(7, 3);
            step();
            n++;
         end
         check("init_len", LW'(n), LW'(8));
      end
      set_rd(7, 3); step();
      check("init_zero", dataout, '0);

      // Masked write.
      set_wr(2, 1, 32'hFFFF_FFFF, {32{8'hAA}}); step();
      set_wr(2, 1, 32'h0000_000F, {32{8'h55}}); step();
      set_rd(2, 1); step();
      check("mask_merge", dataout, {{28{8'hAA}}, {4{8'h55}}});

      // Way isolation: four ways of set 5, read back to back.
      for (int w = 0; w < 4; w++) begin
         set_wr(5, w, 32'hFFFF_FFFF, {32{8'(8'h11 * (w + 1))}});
         step();
      end
      for (int w = 0; w < 4; w++) begin
         set_rd(5, w);
         step();
         pat = {32{8'(8'h11 * (w + 1))}};
         check("way_iso", dataout, pat);
      end
      set_rd(4, 0); step();
      check("set4_zero", dataout, '0);

      // Same-cycle read/write collision on set 0 way 0.
      set_wr(0, 0, 32'h1, {32{8'hFF}});
      set_rd(0, 0);
      step();
`ifdef L2_WAY_DARRAY_WR_BYPASS_EN
      check("bypass", dataout, {{31{8'h00}}, 8'hFF});
`else
      check("no_bypass", dataout, '0);
`endif
      set_rd(0, 0); step();
      check("after_coll", dataout, {{31{8'h00}}, 8'hFF});

      // Random traffic against the model.
      for (int c = 0; c < 60; c++) begin
         if ($urandom_range(0, 1) == 1)
            set_wr($urandom_range(0, 7), $urandom_range(0, 3), $urandom(),
                   {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()});
         if ($urandom_range(0, 2) != 0) set_rd($urandom_range(0, 7), $urandom_range(0, 3));
         step();
      end

      // Reset mid-clear: data written before the first reset must be cleared.
      set_wr(6, 2, 32'hFFFF_FFFF, {32{8'h5A}}); step();
      rst_n = 1'b0; step();
      rst_n = 1'b1;
      repeat (4) step();
      rst_n = 1'b0; step();
      rst_n = 1'b1;
      count_init("reinit_len");
      set_rd(6, 2); step();
      check("reinit_zero", dataout, '0);

      // Three-way instance: way 3 is out of range.
      write_en3 = 1; windex3 = 1; wway3 = 3; wmask3 = '1; datain3 = {32{8'hEE}}; tick3();
      write_en3 = 1; windex3 = 1; wway3 = 2; wmask3 = '1; datain3 = {32{8'h77}}; tick3();
      write_en3 = 1; windex3 = 1; wway3 = 0; wmask3 = '1; datain3 = {32{8'h33}}; tick3();
      read_en3 = 1; rindex3 = 1; rway3 = 3; tick3();
      check("w3_oor_vld", LW'(dataout_valid3), LW'(1));
      check("w3_oor_dat", dataout3, '0);
      read_en3 = 1; rindex3 = 1; rway3 = 2; tick3();
      check("w3_way2", dataout3, {32{8'h77}});
      read_en3 = 1; rindex3 = 1; rway3 = 0; tick3();
      check("w3_way0", dataout3, {32{8'h33}});
      read_en3 = 1; rindex3 = 1; rway3 = 1; tick3();
      check("w3_way1", dataout3, '0);
      write_en3 = 1; windex3 = 1; wway3 = 3; wmask3 = '1; datain3 = {32{8'hFF}};
      read_en3 = 1; rindex3 = 1; rway3 = 3; tick3();
      check("w3_oor_coll_vld", LW'(dataout_valid3), LW'(1));
      check("w3_oor_coll", dataout3, '0);
      tick3();
      check("w3_idle_vld", LW'(dataout_valid3), LW'(0));

      check("sb_drain", LW'(exp_q.size()), LW'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
